// File: rtl/round_judge.sv
// rtl/round_judge.sv - per-round answer arbiter producing framed round-result codes
//
// Purpose: latches the expected answer when a round starts and watches both
// players' submissions. It decides who answered correctly first and then
// emits a 2-bit code pulse framed by 00:
//   00 idle, 01 self wins, 10 opponent wins, 11 draw.
// Optional feature macro: ROUND_TIMEOUT_EN. When it is defined, a round
// left undecided for TIMEOUT_CYC cycles ends in a draw.
//
// Parameters:
//   WIDTH       answer width in bits
//   HOLD_CYC    cycles a non-zero code is held (1..15)
//   GAP_CYC     cycles of 00 after a code before IDLE (2..15)
//   TIMEOUT_CYC round timeout in cycles (only with ROUND_TIMEOUT_EN)
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous reset, active-low
//   START      round-start pulse, honoured only in IDLE
//   EXPECT     correct answer, sampled on an accepted START
//   MY_VALID   self answer strobe
//   MY_ANS     self answer
//   EN_VALID   opponent answer strobe
//   EN_ANS     opponent answer
//   RESULT_OUT registered round code
//   BUSY       registered, high in every state except IDLE
module round_judge #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYC    = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] EXPECT,
  input  logic             MY_VALID,
  input  logic [WIDTH-1:0] MY_ANS,
  input  logic             EN_VALID,
  input  logic [WIDTH-1:0] EN_ANS,
  output logic [1:0]       RESULT_OUT,
  output logic             BUSY
);

  typedef enum logic [1:0] {IDLE, ARMED, REPORT, GAP} state_t;

  state_t           state, n_state;
  logic [WIDTH-1:0] exp_q, n_exp_q;
  logic             my_lock, n_my_lock;
  logic             en_lock, n_en_lock;
  logic [3:0]       cnt, n_cnt;
  logic [1:0]       n_result;

  // Submission qualification: a locked-out player's strobe is ignored.
  logic my_hit, en_hit, my_ok, en_ok, my_bad, en_bad;
  assign my_hit = MY_VALID && !my_lock;
  assign en_hit = EN_VALID && !en_lock;
  assign my_ok  = my_hit && (MY_ANS == exp_q);
  assign en_ok  = en_hit && (EN_ANS == exp_q);
  assign my_bad = my_hit && !my_ok;
  assign en_bad = en_hit && !en_ok;

  logic timeout_hit;
`ifdef ROUND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt, n_tcnt;
  // tcnt is 0 in the first ARMED cycle, so expiry falls on the TIMEOUT_CYC-th cycle.
  assign timeout_hit = (state == ARMED) && (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    n_state   = state;
    n_exp_q   = exp_q;
    n_my_lock = my_lock;
    n_en_lock = en_lock;
    n_cnt     = cnt;
    n_result  = RESULT_OUT;
`ifdef ROUND_TIMEOUT_EN
    n_tcnt    = tcnt;
`endif
    case (state)
      IDLE: begin
        n_result = 2'b00;
        if (START) begin
          n_exp_q   = EXPECT;
          n_my_lock = 1'b0;
          n_en_lock = 1'b0;
          n_state   = ARMED;
`ifdef ROUND_TIMEOUT_EN
          n_tcnt    = '0;
`endif
        end
      end
      ARMED: begin
`ifdef ROUND_TIMEOUT_EN
        n_tcnt = tcnt + 1'b1;
`endif
        // A correct answer always beats a simultaneous wrong one; only when
        // nobody is correct do the lockouts matter.
        if (my_ok || en_ok) begin
          n_result = {en_ok, my_ok};
          n_state  = REPORT;
          n_cnt    = 4'(HOLD_CYC - 1);
        end else begin
          n_my_lock = my_lock || my_bad;
          n_en_lock = en_lock || en_bad;
          if ((n_my_lock && n_en_lock) || timeout_hit) begin
            n_result = 2'b11;
            n_state  = REPORT;
            n_cnt    = 4'(HOLD_CYC - 1);
          end
        end
      end
      REPORT: begin
        if (cnt == 4'd0) begin
          n_result = 2'b00;
          n_state  = GAP;
          n_cnt    = 4'(GAP_CYC - 1);
        end else begin
          n_cnt = cnt - 4'd1;
        end
      end
      GAP: begin
        n_result = 2'b00;
        if (cnt == 4'd0) begin
          n_state = IDLE;
        end else begin
          n_cnt = cnt - 4'd1;
        end
      end
      default: begin
        n_state  = IDLE;
        n_result = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      exp_q      <= '0;
      my_lock    <= 1'b0;
      en_lock    <= 1'b0;
      cnt        <= 4'd0;
      RESULT_OUT <= 2'b00;
      BUSY       <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      state      <= n_state;
      exp_q      <= n_exp_q;
      my_lock    <= n_my_lock;
      en_lock    <= n_en_lock;
      cnt        <= n_cnt;
      RESULT_OUT <= n_result;
      BUSY       <= (n_state != IDLE);
`ifdef ROUND_TIMEOUT_EN
      tcnt       <= n_tcnt;
`endif
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// tb/tb_round_judge.sv - self-checking bench for round_judge
module tb_round_judge;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic [7:0] EXPECT = 8'd0;
  logic       MY_VALID = 1'b0;
  logic [7:0] MY_ANS = 8'd0;
  logic       EN_VALID = 1'b0;
  logic [7:0] EN_ANS = 8'd0;
  logic [1:0] RESULT_OUT;
  logic       BUSY;

  round_judge #(.WIDTH(8), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TIMEOUT_CYC(20)) dut (
    .CLK(CLK), .RST(RST), .START(START), .EXPECT(EXPECT),
    .MY_VALID(MY_VALID), .MY_ANS(MY_ANS), .EN_VALID(EN_VALID), .EN_ANS(EN_ANS),
    .RESULT_OUT(RESULT_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [1:0] sb[$];

  typedef struct {
    logic [7:0]      expv;
    logic [2:0]      mv;
    logic [2:0][7:0] ma;
    logic [2:0]      ev;
    logic [2:0][7:0] ea;
    int              dec;
    logic [1:0]      code;
    bit              start_rep;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 60) begin
      step();
      n++;
    end
    if (BUSY) chk("idle_wait", BUSY, 0);
  endtask

  task automatic run_round(input vec_t v);
    int n;
    wait_idle();
    START = 1'b1;
    EXPECT = v.expv;
    step();
    START = 1'b0;
    EXPECT = 8'hAA;
    chk("busy_after_start", BUSY, 1);
    step();
    for (int i = 0; i <= v.dec; i++) begin
      MY_VALID = v.mv[i];
      MY_ANS   = v.ma[i];
      EN_VALID = v.ev[i];
      EN_ANS   = v.ea[i];
      if (i == v.dec) sb.push_back(v.code);
      step();
      MY_VALID = 1'b0;
      EN_VALID = 1'b0;
      if (i < v.dec) chk("pre_decision_idle_code", RESULT_OUT, 0);
    end
    chk("code", RESULT_OUT, sb.pop_front());
    n = 0;
    while (RESULT_OUT != 2'b00 && n < 20) begin
      if (n == 0 && v.start_rep) begin
        START = 1'b1;
        EXPECT = v.expv;
      end
      step();
      START = 1'b0;
      n++;
    end
    chk("hold_len", n, HOLD);
    n = 0;
    while (BUSY && n < 20) begin
      chk("gap_zero", RESULT_OUT, 0);
      step();
      n++;
    end
    chk("gap_len", n, GAP);
    if (v.start_rep) begin
      repeat (3) begin
        step();
        chk("start_not_queued", BUSY, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'd35,  3'b001, {8'd0, 8'd0, 8'd35},  3'b000, {8'd0, 8'd0, 8'd0},   0, 2'b01, 1'b0};
    vecs[1] = '{8'd21,  3'b001, {8'd0, 8'd0, 8'd21},  3'b001, {8'd0, 8'd0, 8'd21},  0, 2'b11, 1'b0};
    vecs[2] = '{8'd15,  3'b011, {8'd0, 8'd15, 8'd14}, 3'b100, {8'd15, 8'd0, 8'd0},  2, 2'b10, 1'b0};
    vecs[3] = '{8'd9,   3'b001, {8'd0, 8'd0, 8'd3},   3'b010, {8'd0, 8'd4, 8'd0},   1, 2'b11, 1'b1};
    vecs[4] = '{8'd200, 3'b001, {8'd0, 8'd0, 8'd200}, 3'b001, {8'd0, 8'd0, 8'd7},   0, 2'b01, 1'b0};
    vecs[5] = '{8'd255, 3'b000, {8'd0, 8'd0, 8'd0},   3'b001, {8'd0, 8'd0, 8'd255}, 0, 2'b10, 1'b0};
    vecs[6] = '{8'd128, 3'b001, {8'd0, 8'd0, 8'd3},   3'b001, {8'd0, 8'd0, 8'd5},   0, 2'b11, 1'b0};
    vecs[7] = '{8'd60,  3'b010, {8'd0, 8'd60, 8'd0},  3'b001, {8'd0, 8'd0, 8'd61},  1, 2'b01, 1'b0};
    vecs[8] = '{8'd77,  3'b100, {8'd76, 8'd0, 8'd0},  3'b011, {8'd0, 8'd77, 8'd78}, 2, 2'b11, 1'b0};

    RST = 1'b0;
    repeat (3) step();
    chk("reset_result", RESULT_OUT, 0);
    chk("reset_busy", BUSY, 0);
    RST = 1'b1;
    step();

    for (int k = 0; k < 9; k++) run_round(vecs[k]);

    // Reset mid-round abandons it; a later correct answer without START does nothing.
    wait_idle();
    START = 1'b1;
    EXPECT = 8'd50;
    step();
    START = 1'b0;
    step();
    RST = 1'b0;
    step();
    RST = 1'b1;
    chk("midreset_busy", BUSY, 0);
    chk("midreset_result", RESULT_OUT, 0);
    step();
    MY_VALID = 1'b1;
    MY_ANS = 8'd50;
    step();
    MY_VALID = 1'b0;
    repeat (3) begin
      chk("no_start_result", RESULT_OUT, 0);
      chk("no_start_busy", BUSY, 0);
      step();
    end

`ifdef ROUND_TIMEOUT_EN
    START = 1'b1;
    EXPECT = 8'd11;
    step();
    START = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (RESULT_OUT != 2'b00) chk("timeout_early", RESULT_OUT, 0);
    end
    step();
    chk("timeout_code", RESULT_OUT, 3);
    wait_idle();
    chk("timeout_end_busy", BUSY, 0);
`else
    START = 1'b1;
    EXPECT = 8'd11;
    step();
    START = 1'b0;
    repeat (40) step();
    chk("no_timeout_result", RESULT_OUT, 0);
    chk("no_timeout_busy", BUSY, 1);
    MY_VALID = 1'b1;
    MY_ANS = 8'd11;
    step();
    MY_VALID = 1'b0;
    chk("late_answer_code", RESULT_OUT, 1);
    wait_idle();
    chk("late_answer_end_busy", BUSY, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/round_judge.md
# round_judge

Per-round answer arbiter for the two-player factorization game. Captures the expected answer at round start, watches both players' answer submissions, and decides who answered correctly first. Drives the 2-bit round-result code consumed by the HP manager: 00 idle, 01 self wins round, 10 opponent wins round, 11 draw. Each code is a clean pulse framed by 00 so that the downstream 00→non-zero edge detector fires exactly once per round.

## Interface
- WIDTH, 8: answer/expected-value width in bits.
- HOLD_CYC, 4: cycles a non-zero result code is held; legal range 1..15.
- GAP_CYC, 2: minimum cycles of 00 after a code before the next round can start; legal range 2..15.
- TIMEOUT_CYC, 1000: round timeout in cycles; only used when ROUND_TIMEOUT_EN is defined.
- CLK  input  1  clock; all state changes on its rising edge.
- RST  input  1  synchronous reset, active-low.
- START  input  1  single-cycle round-start pulse; honoured only in IDLE.
- EXPECT  input  WIDTH  correct answer; sampled on an accepted START.
- MY_VALID  input  1  self answer strobe, one cycle per submission.
- MY_ANS  input  WIDTH  self answer; qualified by MY_VALID.
- EN_VALID  input  1  opponent answer strobe.
- EN_ANS  input  WIDTH  opponent answer; qualified by EN_VALID.
- RESULT_OUT  output  2  round code to the HP manager; registered.
- BUSY  output  1  high in every state except IDLE; registered.

## Operation
- States: IDLE, ARMED, REPORT, GAP. Reset (RST=0 at a clock edge) gives IDLE, RESULT_OUT=00, BUSY=0, lockouts cleared, counters zero. Reset mid-round abandons the round and emits no code.
- IDLE: RESULT_OUT=00. START=1 latches EXPECT into an internal register, clears both lockout flags, and moves to ARMED.
- ARMED: a player's submission counts only if its VALID is high and that player is not locked out. Correct means the answer equals the latched expected value over all WIDTH bits, unsigned.
  - Only self correct gives code 01. Only opponent correct gives 10. Both correct in the same cycle gives 11.
  - A wrong submission sets that player's lockout for the rest of the round. No code is produced.
  - A correct answer and a wrong answer in the same cycle: the correct player wins. The lockout flag is irrelevant because the round ends.
  - If both lockouts become set, whether together or in sequence, the code is 11.
  - Any code decision moves the block to REPORT.
- REPORT: RESULT_OUT holds the code for exactly HOLD_CYC cycles, then the block moves to GAP. VALID inputs are ignored.
- GAP: RESULT_OUT=00 for exactly GAP_CYC cycles, then IDLE.
- START outside IDLE is ignored and not queued. EXPECT changes outside an accepted START have no effect.

## Timing
- Deciding submission in cycle t: RESULT_OUT shows the code from cycle t+1 through t+HOLD_CYC. It is 00 from t+HOLD_CYC+1. BUSY falls at t+HOLD_CYC+GAP_CYC+1.
- START accepted at cycle s: BUSY=1 from s+1. The earliest counted submission is in cycle s+1.
- A code is always preceded by at least one 00 cycle and followed by GAP_CYC cycles of 00. It never changes directly from one non-zero value to another.
- Counters are 4 bits for HOLD/GAP. The timeout counter is wide enough for TIMEOUT_CYC. Counters do not wrap in normal use.

## Configuration
- ROUND_TIMEOUT_EN defined:
  - ARMED counts cycles from entry.
  - If no decision has been made after TIMEOUT_CYC cycles in ARMED, the block emits code 11 and enters REPORT.
  - A decision in the same cycle as expiry takes priority over the timeout.
- ROUND_TIMEOUT_EN undefined: no timeout counter exists, and ARMED waits indefinitely.

## Test plan
- Reset, then START with EXPECT=8'd35. MY_VALID with MY_ANS=35 two cycles later → RESULT_OUT=01 for 4 cycles, then 00 for 2 cycles, then BUSY=0.
- EXPECT=21. EN_VALID with EN_ANS=21 and MY_VALID with MY_ANS=21 in the same cycle → RESULT_OUT=11 for 4 cycles.
- EXPECT=15. MY_ANS=14 (wrong, locks self), then MY_ANS=15 (ignored), then EN_ANS=15 → RESULT_OUT=10.
- EXPECT=9. MY_ANS=3 then EN_ANS=4 (both wrong) → RESULT_OUT=11. A START pulse during REPORT is ignored, and BUSY stays 1 until the gap ends.
- Pull RST=0 mid-ARMED, then release. A later correct MY_VALID with no new START → RESULT_OUT stays 00, BUSY=0.
- ROUND_TIMEOUT_EN defined with TIMEOUT_CYC=20: START, then no submissions → RESULT_OUT=11 beginning 21 cycles after START.
